// File: rtl/ex_mem_stage.sv
// EX->MEM boundary stage: registers ALU result and controls behind a 2-entry skid
// buffer and issues a one-cycle PC redirect for taken branches / JAL.
// Optional: define MISALIGN_CHECK_EN to flag and squash misaligned word accesses.
module ex_mem_stage #(
  parameter int         XLEN    = 32,
  parameter int         RA_W    = 5,
  parameter logic [2:0] BR_NONE = 3'b000,
  parameter logic [2:0] BR_EQ   = 3'b001,
  parameter logic [2:0] BR_NE   = 3'b010,
  parameter logic [2:0] BR_LT   = 3'b011,
  parameter logic [2:0] BR_GE   = 3'b100,
  parameter logic [2:0] BR_JAL  = 3'b101
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            zero_flag,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RA_W-1:0] rd,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic            reg_wr,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_rd_o,
  output logic            mem_wr_o,
  output logic            reg_wr_o,
  output logic [RA_W-1:0] rd_o,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misaligned
);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [RA_W-1:0] rd;
    logic            mrd;
    logic            mwr;
    logic            rwr;
    logic            mis;
  } entry_t;

  entry_t in_e;
  entry_t out_reg;
  entry_t skid_reg;
  logic   out_valid_reg;
  logic   skid_valid_reg;
  logic   accept;
  logic   drain;
  logic   taken;

  assign accept = ex_valid & ex_ready & !flush;
  assign drain  = out_valid_reg & mem_ready;

  always_comb begin
    in_e.addr  = alu_result;
    in_e.wdata = rs2_data;
    in_e.rd    = rd;
`ifdef MISALIGN_CHECK_EN
    in_e.mis   = (mem_rd | mem_wr) & (alu_result[1:0] != 2'b00);
    in_e.mrd   = mem_rd & !in_e.mis;
    in_e.mwr   = mem_wr & !in_e.mis;
    in_e.rwr   = reg_wr & !in_e.mis;
`else
    in_e.mis   = 1'b0;
    in_e.mrd   = mem_rd;
    in_e.mwr   = mem_wr;
    in_e.rwr   = reg_wr;
`endif
  end

  // Unknown branch codes fall into the default and never redirect.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_NONE: taken = 1'b0;
      BR_EQ:   taken = zero_flag;
      BR_NE:   taken = !zero_flag;
      BR_LT:   taken = alu_result[0];
      BR_GE:   taken = !alu_result[0];
      BR_JAL:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Skid buffer: the skid entry is only ever filled while the output is stalled,
  // and while it is full ex_ready is low, so accept and skid drain never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_reg        <= '0;
      skid_reg       <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!out_valid_reg || drain) begin
      if (skid_valid_reg) begin
        out_reg        <= skid_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_reg       <= in_e;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_reg       <= in_e;
      skid_valid_reg <= 1'b1;
    end
  end

  // Redirect is a pure function of the accept cycle, so a pulse already
  // scheduled survives a flush arriving on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept & taken;
      if (accept & taken) redirect_pc <= pc + imm;
    end
  end

  assign ex_ready   = !skid_valid_reg;
  assign mem_valid  = out_valid_reg;
  assign mem_addr   = out_reg.addr;
  assign mem_wdata  = out_reg.wdata;
  assign rd_o       = out_reg.rd;
  assign mem_rd_o   = out_reg.mrd;
  assign mem_wr_o   = out_reg.mwr;
  assign reg_wr_o   = out_reg.rwr;
  assign misaligned = out_valid_reg & out_reg.mis;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes expected entries/redirects,
// a negedge monitor pops and compares whenever the DUT hands an entry to MEM.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_valid, ex_ready;
  logic [31:0] alu_result, pc, imm, rs2_data;
  logic        zero_flag;
  logic [2:0]  br_type;
  logic [4:0]  rd, rd_o;
  logic        mem_rd, mem_wr, reg_wr;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, redirect_pc;
  logic        mem_rd_o, mem_wr_o, reg_wr_o, redirect_valid, misaligned;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .br_type(br_type), .pc(pc),
    .imm(imm), .rs2_data(rs2_data), .rd(rd), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_wr(reg_wr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .reg_wr_o(reg_wr_o), .rd_o(rd_o),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mrd, mwr, rwr, mis;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } redir_t;

  exp_t   exp_q[$];
  redir_t redir_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one compare per delivered entry and per redirect pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got addr=%h expected no entry", mem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.wdata || rd_o !== e.rd ||
            mem_rd_o !== e.mrd || mem_wr_o !== e.mwr || reg_wr_o !== e.rwr ||
            misaligned !== e.mis || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL xfer: got addr=%h wd=%h rd=%0d r/w/wb/mis=%b%b%b%b cyc=%0d expected addr=%h wd=%h rd=%0d r/w/wb/mis=%b%b%b%b cyc=%0d",
                   mem_addr, mem_wdata, rd_o, mem_rd_o, mem_wr_o, reg_wr_o, misaligned, cyc,
                   e.addr, e.wdata, e.rd, e.mrd, e.mwr, e.rwr, e.mis, e.cyc);
        end else begin
          $display("xfer addr=%h wdata=%h rd=%0d mis=%b cyc=%0d", mem_addr, mem_wdata, rd_o, misaligned, cyc);
        end
      end
    end
    if (rst_n === 1'b1 && redirect_valid === 1'b1) begin
      checks++;
      if (redir_q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected: got pc=%h expected no pulse", redirect_pc);
      end else begin
        redir_t r;
        r = redir_q.pop_front();
        if (redirect_pc !== r.pc || cyc != r.cyc) begin
          errors++;
          $display("FAIL redirect: got pc=%h cyc=%0d expected pc=%h cyc=%0d", redirect_pc, cyc, r.pc, r.cyc);
        end else begin
          $display("redirect pc=%h cyc=%0d", redirect_pc, cyc);
        end
      end
    end
  end

  // Issue one entry; returns 1 ns after the edge that accepted it.
  task automatic send(input logic [31:0] alu, input logic zf, input logic [2:0] bt,
                      input logic [31:0] pcv, input logic [31:0] immv, input logic [31:0] rs2,
                      input logic [4:0] rdv, input logic mrd, input logic mwr,
                      input logic rwr, input bit lat);
    exp_t   e;
    redir_t r;
    logic   tk;
    int     n;
    ex_valid = 1'b1; alu_result = alu; zero_flag = zf; br_type = bt; pc = pcv;
    imm = immv; rs2_data = rs2; rd = rdv; mem_rd = mrd; mem_wr = mwr; reg_wr = rwr;
    n = 0;
    forever begin
      @(negedge clk);
      if (ex_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got ex_ready=%b expected 1 within 50 cycles", ex_ready);
        ex_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.addr = alu; e.wdata = rs2; e.rd = rdv; e.mrd = mrd; e.mwr = mwr; e.rwr = rwr; e.mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if ((mrd | mwr) && alu[1:0] != 2'b00) begin
      e.mis = 1'b1; e.mrd = 1'b0; e.mwr = 1'b0; e.rwr = 1'b0;
    end
`endif
    e.cyc = lat ? cyc : -1;
    exp_q.push_back(e);
    case (bt)
      3'b001:  tk = zf;
      3'b010:  tk = !zf;
      3'b011:  tk = alu[0];
      3'b100:  tk = !alu[0];
      3'b101:  tk = 1'b1;
      default: tk = 1'b0;
    endcase
    if (tk) begin
      r.pc = pcv + immv;
      r.cyc = cyc;
      redir_q.push_back(r);
    end
    ex_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    alu_result = '0; zero_flag = 1'b0; br_type = 3'b000; pc = '0; imm = '0;
    rs2_data = '0; rd = '0; mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0;
    #1;
    chk("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("reset_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("reset_redirect", {31'b0, redirect_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back stream, latency 1, one per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(32'h1000 + 32'(i) * 4, 1'b0, 3'b000, 32'h0, 32'h0, 32'hA000 + 32'(i),
           5'(i + 1), i[0], !i[0], 1'b1, 1'b1);
    chk("stream_cycles", 32'(cyc - c0), 32'd8);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: stall while B sits in output, C goes to skid.
    send(32'h2000, 1'b0, 3'b000, 32'h0, 32'h0, 32'hB000, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    send(32'h2004, 1'b0, 3'b000, 32'h0, 32'h0, 32'hB001, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    mem_ready = 1'b0;
    send(32'h2008, 1'b0, 3'b000, 32'h0, 32'h0, 32'hB002, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ex_ready", {31'b0, ex_ready}, 32'd0);
    chk("bp_hold_addr", mem_addr, 32'h2004);
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Branches: taken BEQ, not-taken BEQ, JAL wrap, unknown code.
    send(32'h0, 1'b1, 3'b001, 32'h100, 32'hFFFF_FFF0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0, 1'b0, 3'b001, 32'h100, 32'hFFFF_FFF0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("beq_not_taken", {31'b0, redirect_valid}, 32'd0);
    @(posedge clk); #1;
    send(32'h0, 1'b0, 3'b101, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'h1, 1'b0, 3'b111, 32'h300, 32'h40, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("unknown_br", {31'b0, redirect_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("redirects_done", 32'(redir_q.size()), 32'd0);

    // Misaligned store then aligned store.
    send(32'h1002, 1'b0, 3'b000, 32'h0, 32'h0, 32'hC0DE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h1004, 1'b0, 3'b000, 32'h0, 32'h0, 32'hBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Flush with both entries full; JAL in skid still pulses.
    mem_ready = 1'b0;
    send(32'h3000, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    send(32'h3004, 1'b0, 3'b101, 32'h400, 32'h20, 32'h2, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_pre_ex_ready", {31'b0, ex_ready}, 32'd0);
    ex_valid = 1'b1; flush = 1'b1; br_type = 3'b101;
    @(posedge clk);
    #1;
    flush = 1'b0; ex_valid = 1'b0;
    exp_q.delete();
    chk("flush_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("flush_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("flush_no_redirect", {31'b0, redirect_valid}, 32'd0);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Async reset mid-transfer with a redirect pending on the outputs.
    mem_ready = 1'b0;
    send(32'h4000, 1'b0, 3'b010, 32'h200, 32'h10, 32'h5, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("rst_redirect", {31'b0, redirect_valid}, 32'd0);
    exp_q.delete();
    redir_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1; mem_ready = 1'b1;
    send(32'h5000, 1'b0, 3'b000, 32'h0, 32'h0, 32'h6, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_redir_empty", 32'(redir_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
